// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache controller.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   // RV32I funct3 encodings for loads and stores
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int OFFSET_BITS    = 2;
   localparam int DEF_INDEX_BITS = 5;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TAG_BITS   = DEF_DATA_WIDTH - DEF_INDEX_BITS - OFFSET_BITS;

endpackage

// File: rtl/dcache_load_align.sv
// Load formatting: selects the byte/halfword lane and sign- or zero-extends it.
module dcache_load_align
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]  word,
   input  logic [OFFSET_BITS-1:0] offset,
   input  logic [2:0]             funct3,
   output logic [DATA_WIDTH-1:0]  data
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      case (offset)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         default: byte_s = word[31:24];
      endcase
      half_s = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_LB:   data = DATA_WIDTH'(byte_s);
         F3_LH:   data = DATA_WIDTH'(half_s);
         F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_s};
         F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_s};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with one-word lines.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic [2:0]            memcontrol,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int LINES    = 2**INDEX_BITS;
   localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - OFFSET_BITS;

   state_t                  state;
   logic [LINES-1:0]        valid;
   logic [TAG_BITS-1:0]     tag_mem  [LINES];
   logic [DATA_WIDTH-1:0]   data_mem [LINES];

   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_BITS-1:0]     tag;
   logic [OFFSET_BITS-1:0]  off;
   logic                    hit;
   logic                    lookup;
   logic                    start;
   logic [DATA_WIDTH-1:0]   st_data;
   logic [3:0]              st_strb;
   logic [DATA_WIDTH-1:0]   aligned;

   function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] d);
      case (f3)
         F3_SB:   return {4{d[7:0]}};
         F3_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Misaligned halfword/word stores drop the offending offset bits
   function automatic logic [3:0] lane_strb(input logic [2:0] f3,
                                            input logic [OFFSET_BITS-1:0] o);
      case (f3)
         F3_SB:   return 4'b0001 << o;
         F3_SH:   return o[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                   input logic [DATA_WIDTH-1:0] new_w,
                                                   input logic [3:0] strb);
      logic [DATA_WIDTH-1:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   assign idx     = addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
   assign tag     = addr[DATA_WIDTH-1 -: TAG_BITS];
   assign off     = addr[OFFSET_BITS-1:0];
   assign hit     = valid[idx] && (tag_mem[idx] == tag);
   assign lookup  = (state == IDLE) && req_valid;
   assign start   = lookup && (we || !hit);
   assign st_data = lane_data(memcontrol, wd);
   assign st_strb = lane_strb(memcontrol, off);

   dcache_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
      .word   (data_mem[idx]),
      .offset (off),
      .funct3 (memcontrol),
      .data   (aligned)
   );

   // Hits answer in the lookup cycle, so stall and read_data stay combinational
   always_comb begin
      stall     = 1'b0;
      read_data = '0;
      if (!rst) begin
         case (state)
            IDLE:          if (req_valid) begin
                              if (we || !hit) stall = 1'b1;
                              else            read_data = aligned;
                           end
            REFILL, WRITE: stall = 1'b1;
            RESP:          if (!we) read_data = aligned;
            default:       ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         valid     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wstrb <= '0;
`ifdef DCACHE_STATS_EN
         hit_count  <= '0;
         miss_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mem_req   <= 1'b1;
                  mem_we    <= we;
                  mem_wstrb <= we ? st_strb : 4'b0000;
                  state     <= we ? WRITE : REFILL;
               end
`ifdef DCACHE_STATS_EN
               if (lookup) begin
                  if (hit) hit_count  <= hit_count + 32'd1;
                  else     miss_count <= miss_count + 32'd1;
               end
`endif
            end
            REFILL: if (mem_ack) begin
               valid[idx] <= 1'b1;
               mem_req    <= 1'b0;
               state      <= RESP;
            end
            WRITE: if (mem_ack) begin
               mem_req   <= 1'b0;
               mem_we    <= 1'b0;
               mem_wstrb <= '0;
               state     <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage and request payload carry no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (start) begin
         mem_addr  <= {addr[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
         mem_wdata <= st_data;
      end
      if (lookup && we && hit)
         data_mem[idx] <= merge(data_mem[idx], st_data, st_strb);
      if ((state == REFILL) && mem_ack) begin
         data_mem[idx] <= mem_rdata;
         tag_mem[idx]  <= tag;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a word-addressed cache/memory reference model.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wd = '0;
   logic [2:0]  memcontrol = 3'd2;
   logic [31:0] read_data;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   dcache_ctrl #(.INDEX_BITS(5), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .we         (we),
      .addr       (addr),
      .wd         (wd),
      .memcontrol (memcontrol),
      .read_data  (read_data),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: backing memory by word address, 32 lines each remembering its word address
   bit [31:0] mem [bit [29:0]];
   bit        m_valid [32];
   bit [31:0] m_word  [32];
   bit [31:0] m_data  [32];
   int        m_hits = 0;
   int        m_misses = 0;

   function automatic bit [31:0] mem_rd(input bit [29:0] w);
      if (mem.exists(w)) return mem[w];
      return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit [31:0] fmt_load(input bit [31:0] word, input bit [1:0] o, input bit [2:0] f3);
      bit [31:0] b, h;
      b = (word >> (8 * int'(o))) & 32'h0000_00FF;
      h = (word >> (16 * int'(o[1]))) & 32'h0000_FFFF;
      case (f3)
         3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
         3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   function automatic bit [3:0] exp_strb(input bit [2:0] f3, input bit [1:0] o);
      case (f3)
         3'd0:    return 4'(1 << int'(o));
         3'd1:    return o[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic bit [31:0] exp_wdata(input bit [2:0] f3, input bit [31:0] d);
      case (f3)
         3'd0:    return {4{d[7:0]}};
         3'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic bit [31:0] apply_strb(input bit [31:0] o, input bit [31:0] n, input bit [3:0] s);
      bit [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   task automatic access(input bit st, input bit [31:0] a, input bit [31:0] d, input bit [2:0] f3,
                         input int delay, output bit [31:0] got, output bit stalled);
      bit [29:0] w;
      int        li;
      bit        hit;
      bit [3:0]  sb;
      bit [31:0] swd;
      w   = a[31:2];
      li  = int'(w[4:0]);
      hit = m_valid[li] && (m_word[li] == {2'b00, w});
      sb  = exp_strb(f3, a[1:0]);
      swd = exp_wdata(f3, d);
      @(negedge clk);
      req_valid = 1'b1; we = st; addr = a; wd = d; memcontrol = f3;
      #1;
      stalled = stall;
      got     = read_data;
      if (hit) m_hits++; else m_misses++;
      if (!st && hit) begin
         check("hit_stall", stall, 32'd0);
         check("hit_mem_req", mem_req, 32'd0);
         check("hit_data", read_data, fmt_load(m_data[li], a[1:0], f3));
      end else begin
         check("lookup_stall", stall, 32'd1);
         if (st && hit) m_data[li] = apply_strb(m_data[li], swd, sb);
         for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            check("busy_stall", stall, 32'd1);
            check("mem_req", mem_req, 32'd1);
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            check("mem_we", mem_we, {31'd0, st});
            if (st) begin
               check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, sb});
               check("mem_wdata", mem_wdata, swd);
            end
            if (k == delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_rd(w);
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
         if (st) mem[w] = apply_strb(mem_rd(w), swd, sb);
         else begin
            m_valid[li] = 1'b1;
            m_word[li]  = {2'b00, w};
            m_data[li]  = mem_rd(w);
         end
         check("resp_stall", stall, 32'd0);
         check("resp_mem_req", mem_req, 32'd0);
         if (!st) check("resp_data", read_data, fmt_load(m_data[li], a[1:0], f3));
         got = read_data;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      check("idle_stall", stall, 32'd0);
      check("idle_rdata", read_data, 32'd0);
   endtask

   task automatic reset_mid_refill();
      @(negedge clk);
      req_valid = 1'b1; we = 1'b0; addr = 32'h0000_0300; memcontrol = F3_LW;
      @(posedge clk); #1;
      check("pre_rst_req", mem_req, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_stall", stall, 32'd0);
      check("rst_mem_req", mem_req, 32'd0);
      check("rst_mem_we", mem_we, 32'd0);
      check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("rst_rdata", read_data, 32'd0);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("late_ack_stall", stall, 32'd0);
      check("late_ack_req", mem_req, 32'd0);
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   bit [31:0] got;
   bit        stl;
   bit [2:0]  ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   bit [2:0]  st_ops [3] = '{3'd0, 3'd1, 3'd2};

   initial begin
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      req_valid = 1'b1; addr = 32'h0000_0100; memcontrol = F3_LW;
      #1;
      check("reset_stall", stall, 32'd0);
      check("reset_mem_req", mem_req, 32'd0);
      check("reset_mem_we", mem_we, 32'd0);
      check("reset_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("reset_rdata", read_data, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      mem[30'h40] = 32'h80FF_7F01;
      access(1'b0, 32'h0000_0100, 32'd0, F3_LW, 1, got, stl);
      check("cold_lw_data", got, 32'h80FF_7F01);
      access(1'b0, 32'h0000_0100, 32'd0, F3_LW, 0, got, stl);
      check("warm_lw_nostall", {31'd0, stl}, 32'd0);
      access(1'b0, 32'h0000_0101, 32'd0, F3_LB, 0, got, stl);
      check("lb_101", got, 32'h0000_007F);
      access(1'b0, 32'h0000_0103, 32'd0, F3_LB, 0, got, stl);
      check("lb_103", got, 32'hFFFF_FF80);
      access(1'b0, 32'h0000_0102, 32'd0, F3_LHU, 0, got, stl);
      check("lhu_102", got, 32'h0000_80FF);
      access(1'b1, 32'h0000_0102, 32'h0000_00AB, F3_SB, 0, got, stl);
      access(1'b0, 32'h0000_0100, 32'd0, F3_LW, 0, got, stl);
      check("lw_after_sb", got, 32'h80AB_7F01);
      check("lw_after_sb_hit", {31'd0, stl}, 32'd0);
      access(1'b0, 32'h0000_0180, 32'd0, F3_LW, 2, got, stl);
      check("evict_miss", {31'd0, stl}, 32'd1);
      access(1'b0, 32'h0000_0100, 32'd0, F3_LW, 1, got, stl);
      check("evicted_remiss", {31'd0, stl}, 32'd1);
      check("evicted_data", got, 32'h80AB_7F01);

      reset_mid_refill();

      access(1'b0, 32'h0000_0100, 32'd0, F3_LW, 0, got, stl);
      check("post_rst_miss", {31'd0, stl}, 32'd1);
      access(1'b0, 32'h0000_0100, 32'd0, F3_LW, 0, got, stl);
      access(1'b0, 32'h0000_0101, 32'd0, F3_LB, 0, got, stl);
      access(1'b0, 32'h0000_0104, 32'd0, F3_LW, 3, got, stl);
      access(1'b0, 32'h0000_0106, 32'd0, F3_LH, 0, got, stl);
      access(1'b1, 32'h0000_0200, 32'h1234_5678, F3_SW, 1, got, stl);
`ifdef DCACHE_STATS_EN
      check("stats_hit", hit_count, 32'd3);
      check("stats_miss", miss_count, 32'd3);
`endif

      for (int n = 0; n < 300; n++) begin
         bit        st;
         bit [31:0] a;
         bit [2:0]  f3;
         st = ($urandom_range(0, 9) < 3);
         a  = 32'h0000_1000 | (32'($urandom_range(0, 2)) << 7)
                            | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         f3 = st ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
         access(st, a, $urandom, f3, $urandom_range(0, 3), got, stl);
      end
`ifdef DCACHE_STATS_EN
      check("stats_hit_final", hit_count, 32'(m_hits));
      check("stats_miss_final", miss_count, 32'(m_misses));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5, meaning the set-index width, giving 2^INDEX_BITS one-word lines (direct-mapped).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the word and address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU memory-stage access valid (load or store).
REQ-006 SHALL have port we  input  1  CPU store (1) or load (0).
REQ-007 SHALL have port addr  input  32  CPU byte address (ALU result).
REQ-008 SHALL have port wd  input  32  CPU store data, right-aligned.
REQ-009 SHALL have port memcontrol  input  3  RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
REQ-010 SHALL have port read_data  output  32  load result, sign- or zero-extended per memcontrol.
REQ-011 SHALL have port stall  output  1  holds the CPU pipeline; the CPU keeps all request inputs stable while it is high.
REQ-012 SHALL have port mem_req  output  1  backing-memory request.
REQ-013 SHALL have port mem_we  output  1  backing-memory write (1) or read (0).
REQ-014 SHALL have port mem_addr  output  32  word-aligned backing-memory address (addr[1:0] forced to 0).
REQ-015 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-016 SHALL have port mem_wstrb  output  4  byte-lane enables for writes.
REQ-017 SHALL have port mem_ack  input  1  backing memory completed the request; mem_rdata is valid in the same cycle.
REQ-018 SHALL have port mem_rdata  input  32  backing-memory read word.

Function
REQ-019 SHALL implement FSM states IDLE, REFILL, WRITE and RESP.
REQ-020 In IDLE, for a load whose tag matches a valid line: stall=0 and read_data formatted from the line in the same cycle (combinational hit), with no state change.
REQ-021 In IDLE, for a load miss: stall=1 combinationally in the same cycle; next state REFILL.
REQ-022 In IDLE, for any store: stall=1 in the same cycle; next state WRITE.
  - Store hit: line bytes merged per mem_wstrb on entry to WRITE.
  - Store miss: no allocate; line left unchanged.
REQ-023 In REFILL/WRITE: mem_req=1, stall=1, and mem_addr/mem_we/mem_wdata/mem_wstrb held stable until mem_ack is sampled high.
  - An ack in the first cycle of mem_req is legal.
REQ-024 On an ack in REFILL, SHALL write mem_rdata into the line, set the tag and valid bit, and go to RESP; on an ack in WRITE, SHALL go to RESP.
  - mem_req SHALL drop in RESP.
REQ-025 RESP SHALL last one cycle: stall=0; read_data formatted from the line just refilled; no new lookup or memory access; next state IDLE.
REQ-026 Latency SHALL be: load hit 0 extra cycles; miss or store = (cycles to ack) + 1.
REQ-027 Byte lane SHALL be addr[1:0] for byte access and addr[1] for halfword access.
  - Misaligned halfword/word accesses SHALL ignore the offending low address bits.
  - SB/SH replicate wd across lanes on mem_wdata.
REQ-028 With req_valid=0 in IDLE: stall=0, mem_req=0, read_data=0.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, clear all valid bits, and drive stall=0, mem_req=0, mem_we=0, mem_wstrb=0, read_data=0, and stats counters to 0.
REQ-030 Reset mid-REFILL/WRITE SHALL abandon the transaction; a late mem_ack SHALL be ignored in IDLE.

Configuration
REQ-031 Macro DCACHE_STATS_EN, when defined, SHALL add outputs hit_count and miss_count (32-bit), incremented once per IDLE lookup (hit or miss respectively, loads and stores) and wrapping at 2^32; when undefined, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-032 Package dcache_pkg SHALL hold the FSM state enum, the funct3 load/store encodings, and the tag/index/offset width constants.
REQ-033 Load formatting (lane select plus sign/zero extension) SHALL be sub-module dcache_load_align.

Verification
REQ-034 Cold LW 0x100 with ack after 2 cycles -> stall high 3 cycles, one read with mem_addr=0x100, RESP read_data=mem_rdata; repeated LW 0x100 -> stall=0, no mem_req.
REQ-035 After line 0x100=0x80FF7F01: LB 0x101 -> 0x0000007F; LB 0x103 -> 0xFFFFFF80; LHU 0x102 -> 0x000080FF.
REQ-036 SB 0x102 wd=0xAB on cached line -> mem_wstrb=0100, mem_wdata=0xABABABAB, then LW 0x100 hits with 0x80AB7F01.
REQ-037 LW 0x100 then LW 0x180 (INDEX_BITS=5, same index) -> second access misses, refills and evicts; LW 0x100 misses again.
REQ-038 rst asserted during REFILL, then late mem_ack -> state IDLE, no line valid, stall=0.
REQ-039 With DCACHE_STATS_EN: 3 hits, 2 misses, 1 store miss -> hit_count=3, miss_count=3.
